// File: rtl/rlc_pio_pkg.sv
// Shared definitions for the RLC game PIO input port: register offsets,
// edge-capture modes and a constant clog2 helper.
package rlc_pio_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_MASK = 2'd1,
    REG_RSVD = 2'd2,
    REG_EDGE = 2'd3
  } reg_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rlc_pio_in_chan.sv
// One PIO input channel: input register (two-flop synchroniser when
// RLC_PIO_IN_SYNC_EN is defined), edge detect, MASK/EDGE registers, irq.
module rlc_pio_in_chan
  import rlc_pio_pkg::*;
#(
  parameter int WIDTH     = 9,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  input  logic             mask_we_i,
  input  logic             edge_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] mask_o,
  output logic [WIDTH-1:0] edge_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] d_q, prev_q, mask_q, mask_d, edge_q, edge_d, det;

`ifdef RLC_PIO_IN_SYNC_EN
  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      d_q    <= '0;
    end else begin
      meta_q <= din_i;
      d_q    <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= '0;
    else       d_q <= din_i;
  end
`endif

  always_comb begin
    case (EDGE_MODE)
      EDGE_FALL: det = ~d_q & prev_q;
      EDGE_ANY:  det = d_q ^ prev_q;
      default:   det = d_q & ~prev_q;
    endcase
  end

  // A fresh edge on a bit overrides a W1C to that same bit.
  assign edge_d = (edge_q & ~(edge_we_i ? wdata_i : '0)) | det;
  assign mask_d = mask_we_i ? wdata_i : mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= d_q;
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

  assign data_o = d_q;
  assign mask_o = mask_q;
  assign edge_o = edge_q;
  assign irq_o  = |(edge_q & mask_q);

endmodule

// File: rtl/rlc_game_pio_in.sv
// Multi-channel Avalon-MM PIO input port with edge capture and masked irq.
// Build option: define RLC_PIO_IN_SYNC_EN for two-flop input synchronisers.
module rlc_game_pio_in
  import rlc_pio_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int WIDTH     = 9,
  parameter int EDGE_MODE = EDGE_RISE,
  parameter int ADDR_W    = clog2(NUM_CH) + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  input  logic [NUM_CH*WIDTH-1:0] in_port,
  output logic [31:0]             readdata,
  output logic                    irq
);

  logic [ADDR_W-1:0] ch_sel;
  reg_e              reg_sel;
  logic              wr_en;
  logic [WIDTH-1:0]  data_a [NUM_CH];
  logic [WIDTH-1:0]  mask_a [NUM_CH];
  logic [WIDTH-1:0]  edge_a [NUM_CH];
  logic [NUM_CH-1:0] irq_a;
  logic [WIDTH-1:0]  rd_val;
  logic [31:0]       readdata_d, readdata_q;
  logic              unused_wdata;

  assign ch_sel       = address >> 2;
  assign reg_sel      = reg_e'(address[1:0]);
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Channel indices with no instance never match a hit, so out-of-range
  // writes fall through and reads return zero.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic chan_hit;
    assign chan_hit = (ch_sel == ADDR_W'(gi));

    rlc_pio_in_chan #(
      .WIDTH     (WIDTH),
      .EDGE_MODE (EDGE_MODE)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .din_i     (in_port[gi*WIDTH +: WIDTH]),
      .mask_we_i (wr_en & chan_hit & (reg_sel == REG_MASK)),
      .edge_we_i (wr_en & chan_hit & (reg_sel == REG_EDGE)),
      .wdata_i   (writedata[WIDTH-1:0]),
      .data_o    (data_a[gi]),
      .mask_o    (mask_a[gi]),
      .edge_o    (edge_a[gi]),
      .irq_o     (irq_a[gi])
    );
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == ADDR_W'(i)) begin
        case (reg_sel)
          REG_DATA: rd_val = data_a[i];
          REG_MASK: rd_val = mask_a[i];
          REG_EDGE: rd_val = edge_a[i];
          default:  rd_val = '0;
        endcase
      end
    end
  end

  assign readdata_d = 32'(rd_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_a;

endmodule

// File: tb/tb_rlc_game_pio_in.sv
// Directed bench for rlc_game_pio_in: a default instance (2x9, rising) and a
// 3x4 any-edge instance for fall capture and out-of-range decode.
module tb_rlc_game_pio_in;

`ifdef RLC_PIO_IN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk, reset;
  logic [2:0]  addr0;
  logic        cs0, wn0;
  logic [31:0] wd0, rd0;
  logic [17:0] in0;
  logic        irq0;
  logic [3:0]  addr2;
  logic        cs2, wn2;
  logic [31:0] wd2, rd2;
  logic [11:0] in2;
  logic        irq2;

  int n_checks = 0;
  int n_errors = 0;

  rlc_game_pio_in dut0 (
    .clk        (clk),
    .reset      (reset),
    .address    (addr0),
    .chipselect (cs0),
    .write_n    (wn0),
    .writedata  (wd0),
    .in_port    (in0),
    .readdata   (rd0),
    .irq        (irq0)
  );

  rlc_game_pio_in #(.NUM_CH(3), .WIDTH(4), .EDGE_MODE(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .address    (addr2),
    .chipselect (cs2),
    .write_n    (wn2),
    .writedata  (wd2),
    .in_port    (in2),
    .readdata   (rd2),
    .irq        (irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("check %s: got %h ok", tag, got);
    end
  endtask

  task automatic wr0(input logic [2:0] a, input logic [31:0] d);
    cs0 = 1'b1; wn0 = 1'b0; addr0 = a; wd0 = d;
    @(negedge clk);
    cs0 = 1'b0; wn0 = 1'b1;
  endtask

  task automatic rdchk0(input logic [2:0] a, input string tag, input logic [31:0] exp);
    addr0 = a;
    @(negedge clk);
    check_eq(tag, rd0, exp);
  endtask

  task automatic wr2(input logic [3:0] a, input logic [31:0] d);
    cs2 = 1'b1; wn2 = 1'b0; addr2 = a; wd2 = d;
    @(negedge clk);
    cs2 = 1'b0; wn2 = 1'b1;
  endtask

  task automatic rdchk2(input logic [3:0] a, input string tag, input logic [31:0] exp);
    addr2 = a;
    @(negedge clk);
    check_eq(tag, rd2, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cs0 = 1'b0; wn0 = 1'b1; addr0 = '0; wd0 = '0; in0 = '0;
    cs2 = 1'b0; wn2 = 1'b1; addr2 = '0; wd2 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_rd0", rd0, 32'h0);
    check_eq("rst_irq0", irq0, 32'h0);
    check_eq("rst_irq2", irq2, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // DATA latency on channel 1
    addr0 = 3'd4;
    in0   = {9'h1A5, 9'h000};
    repeat (LAT) @(negedge clk);
    check_eq("data_early", rd0, 32'h0);
    @(negedge clk);
    check_eq("data_ch1", rd0, 32'h0000_01A5);
    check_eq("irq_unmasked", irq0, 32'h0);
    rdchk0(3'd7, "edge_ch1_unmasked", 32'h1A5);

    // Rising capture with mask, then W1C
    wr0(3'd1, 32'hFFFF_FE01);
    rdchk0(3'd1, "mask_ch0", 32'h001);
    check_eq("irq_mask_only", irq0, 32'h0);
    in0[0] = 1'b1;
    repeat (LAT) @(negedge clk);
    check_eq("irq_early", irq0, 32'h0);
    @(negedge clk);
    check_eq("irq_rise", irq0, 32'h1);
    rdchk0(3'd3, "edge_ch0", 32'h001);
    wr0(3'd3, 32'h1);
    check_eq("irq_w1c", irq0, 32'h0);
    rdchk0(3'd3, "edge_clr", 32'h0);

    // W1C coinciding with a new rising edge: set wins
    in0[0] = 1'b0; repeat (4) @(negedge clk);
    in0[0] = 1'b1; repeat (4) @(negedge clk);
    check_eq("irq_rearm", irq0, 32'h1);
    in0[0] = 1'b0; repeat (4) @(negedge clk);
    check_eq("irq_fall_ignored", irq0, 32'h1);
    in0[0] = 1'b1;
    repeat (LAT) @(negedge clk);
    wr0(3'd3, 32'h1);
    check_eq("irq_set_wins", irq0, 32'h1);
    rdchk0(3'd3, "edge_set_wins", 32'h001);
    wr0(3'd3, 32'h1);
    check_eq("irq_w1c2", irq0, 32'h0);

    // Any-edge instance: falling transition captured
    in2 = 12'h005;
    repeat (4) @(negedge clk);
    rdchk2(4'd3, "edge2_rise", 32'h5);
    wr2(4'd3, 32'hF);
    rdchk2(4'd3, "edge2_clr", 32'h0);
    wr2(4'd1, 32'h4);
    check_eq("irq2_idle", irq2, 32'h0);
    in2 = 12'h001;
    repeat (LAT) @(negedge clk);
    check_eq("fall_early", irq2, 32'h0);
    @(negedge clk);
    check_eq("fall_irq", irq2, 32'h1);
    rdchk2(4'd3, "fall_edge", 32'h4);

    // Out-of-range channel and reserved register
    wr2(4'd13, 32'hF);
    wr2(4'd15, 32'hF);
    rdchk2(4'd13, "oob_mask", 32'h0);
    rdchk2(4'd15, "oob_edge", 32'h0);
    rdchk2(4'd9,  "mask_ch2_untouched", 32'h0);
    rdchk2(4'd1,  "mask_ch0_kept", 32'h4);
    wr2(4'd2, 32'hF);
    rdchk2(4'd2, "rsvd", 32'h0);
    cs2 = 1'b0; wn2 = 1'b0; addr2 = 4'd1; wd2 = 32'h0;
    @(negedge clk);
    wn2 = 1'b1;
    rdchk2(4'd1, "cs_gate", 32'h4);
    rdchk2(4'd0, "data2_ch0", 32'h1);

    // Asynchronous reset mid-cycle with inputs held high
    in0 = 18'h3FFFF;
    wr0(3'd1, 32'h1FF);
    repeat (4) @(negedge clk);
    rdchk0(3'd0, "pre_rst_data", 32'h1FF);
    check_eq("pre_rst_irq", irq0, 32'h1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_async_rd", rd0, 32'h0);
    check_eq("rst_async_irq", irq0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rdchk0(3'd1, "rst_mask", 32'h0);
    check_eq("rst_irq_after", irq0, 32'h0);
    repeat (4) @(negedge clk);
    rdchk0(3'd3, "rst_rise_capture", 32'h1FF);
    rdchk0(3'd0, "rst_data", 32'h1FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
